kevin_stream_framer: RTL and testbench
======================================

Name: kevin_stream_framer

Overview:
- Upstream feeder and monitor for the 4-bit Kevin number classifier.
- Accepts a framed serial bit stream and assembles the bits MSB-first into nibbles.
- For each completed nibble, presents the nibble with a registered valid pulse and its Kevin classification (Kevin set = {1,5,6,7,9,10,12,14}).
- Keeps a saturating hit counter and raises a sticky alarm on a run of consecutive Kevin nibbles.

Parameters:
- CNT_W, 8, width of hit_count; count saturates at 2^CNT_W-1.
- RUN_LEN, 3, number of consecutive Kevin nibbles within one frame that sets run_alarm; legal range 1..15.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- frame_start  input  1  starts a new frame; discards any partial nibble.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is accepted this cycle (only in COLLECT, or with frame_start).
- cnt_clr  input  1  synchronously clears hit_count.
- alarm_clr  input  1  synchronously clears run_alarm.
- nibble  output  4  last completed nibble; first bit received is nibble[3].
- nibble_valid  output  1  one-cycle pulse; nibble and kevin_hit are valid.
- kevin_hit  output  1  1 iff nibble is in the Kevin set; qualified by nibble_valid.
- hit_count  output  CNT_W  saturating count of Kevin nibbles.
- run_alarm  output  1  sticky; set when the consecutive-hit run reaches RUN_LEN.
- busy  output  1  1 in COLLECT state.

Behaviour:
- Reset (rst=1 at a clock edge) has priority over all other inputs. It forces:
  - state IDLE; bit_cnt 0; shift register 0;
  - nibble 0, nibble_valid 0, kevin_hit 0;
  - hit_count 0, run_cnt 0, run_alarm 0, busy 0.
- FSM states:
  - IDLE: bit_valid is ignored. frame_start moves to COLLECT.
  - COLLECT: accepts bits. Stays in COLLECT indefinitely; the frame is closed only by the next frame_start or by rst.
- frame_start, in either state:
  - bit_cnt <- 0, shift register <- 0, run_cnt <- 0, state <- COLLECT.
  - If bit_valid is also high, that bit is the first bit of the new frame (bit_cnt becomes 1).
  - A partial nibble from the old frame is dropped and no nibble_valid is generated.
  - This also applies when the dropped bit would have been the old frame's 4th bit: frame_start wins.
- Bit accept in COLLECT: shift <- {shift[2:0], bit_in}; bit_cnt increments.
- When the 4th bit is accepted (bit_cnt=3 before the edge):
  - On the same edge: nibble <- {shift[2:0], bit_in}, kevin_hit <- class(that value), nibble_valid <- 1, bit_cnt <- 0.
  - Latency: outputs are visible the cycle after the 4th bit is sampled.
  - nibble_valid is high for exactly one cycle. nibble and kevin_hit hold their values until the next completion.
- Gaps: bits need not be consecutive. bit_valid=0 cycles stall accumulation with no timeout.
- Classification: registered lookup. class(v) = KEVIN_MASK[v], with KEVIN_MASK = 16'h56E2.
- hit_count:
  - Increments on each completion with kevin_hit=1.
  - Saturates at all-ones.
  - cnt_clr has priority over a same-cycle increment; the result is 0.
- run_cnt (internal, 4-bit):
  - On a completion, a hit increments it (saturating at 15) and a non-hit clears it.
  - Cleared by frame_start, so runs never span frames.
- run_alarm:
  - Set on the completion edge where run_cnt+1 reaches RUN_LEN.
  - Stays set until alarm_clr or rst.
  - A same-cycle set and alarm_clr leaves run_alarm = 1 (set wins).
- busy = (state == COLLECT), registered.

Decomposition:
- Shared package kevin_pkg holds:
  - KEVIN_MASK (16'h56E2);
  - the state enum {IDLE, COLLECT};
  - NIB_W = 4.
- One natural sub-module: kevin_lut, a combinational 4-bit mask lookup (in[3:0] -> hit) driven from KEVIN_MASK. It is instantiated once and its output is registered in the framer.
- Framer FSM, shift register and counters stay in kevin_stream_framer.

Test Plan:
- Reset mid-frame after 2 bits -> all outputs 0, busy=0; later bits with no frame_start produce no nibble_valid.
- frame_start, then bits 0,1,1,0 on consecutive cycles -> one cycle after the 4th bit: nibble=6, kevin_hit=1, nibble_valid pulse of 1 cycle, hit_count=1.
- Frame carrying the nibbles 3, 9, 10, 12 (RUN_LEN=3) -> kevin_hit sequence 0,1,1,1; run_alarm rises with the 12; alarm_clr clears it; a same-cycle set plus alarm_clr leaves it at 1.
- frame_start after 3 bits of 1,0,1, then bits 0,0,0,1 -> only nibble=1 is reported (hit); no nibble from the dropped partial nibble; run_cnt restarts.
- Bits 1,1,1,1 with bit_valid gaps of 0-3 cycles -> nibble=15, kevin_hit=0, run_cnt cleared, hit_count unchanged.
- CNT_W=2 with 5 hit nibbles -> hit_count saturates at 3; cnt_clr in the same cycle as a hit completion -> hit_count=0.

Source files
------------

// File: rtl/kevin_pkg.sv
// Shared definitions for the Kevin nibble framer: class mask, nibble width, FSM states.
package kevin_pkg;

  localparam int NIB_W = 4;

  // Bit v set <=> v is a Kevin number: {1,5,6,7,9,10,12,14}
  localparam logic [15:0] KEVIN_MASK = 16'h56E2;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/kevin_lut.sv
// Combinational Kevin-set membership lookup for one nibble.
module kevin_lut
  import kevin_pkg::*;
(
  input  logic [NIB_W-1:0] value,
  output logic             hit
);

  assign hit = KEVIN_MASK[value];

endmodule

// File: rtl/kevin_stream_framer.sv
// Frames a serial bit stream into MSB-first nibbles, classifies each one and
// tracks a saturating hit count plus a sticky alarm on runs of Kevin nibbles.
module kevin_stream_framer
  import kevin_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 3
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             cnt_clr,
  input  logic             alarm_clr,
  output logic [NIB_W-1:0] nibble,
  output logic             nibble_valid,
  output logic             kevin_hit,
  output logic [CNT_W-1:0] hit_count,
  output logic             run_alarm,
  output logic             busy
);

  localparam logic [4:0] RUN_LEN_V = 5'(RUN_LEN);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [3:0] sat_inc_run(input logic [3:0] v);
    return (&v) ? v : v + 4'd1;
  endfunction

  state_t state, state_nxt;

  logic [2:0]       shift_p0;
  logic [1:0]       bit_cnt_p0;
  logic [3:0]       run_cnt_p0;
  logic [NIB_W-1:0] nibble_p1;
  logic             hit_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             alarm_p1;

  logic             accept;
  logic             done;
  logic [NIB_W-1:0] nib_word;
  logic             lut_hit;
  logic             alarm_set;

  // frame_start always wins over a plain bit accept, even on a 4th bit
  assign accept    = (state == COLLECT) && bit_valid && !frame_start;
  assign done      = accept && (bit_cnt_p0 == 2'd3);
  assign nib_word  = {shift_p0, bit_in};
  assign alarm_set = done && lut_hit && (({1'b0, run_cnt_p0} + 5'd1) == RUN_LEN_V);

  kevin_lut u_lut (
    .value (nib_word),
    .hit   (lut_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_start) state_nxt = COLLECT;
  end

  // Stage p0: bit accumulation; stage p1: completed nibble, class and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_p0   <= '0;
      bit_cnt_p0 <= '0;
      run_cnt_p0 <= '0;
      nibble_p1  <= '0;
      hit_p1     <= 1'b0;
      vld_p1     <= 1'b0;
      cnt_p1     <= '0;
      alarm_p1   <= 1'b0;
    end else begin
      vld_p1 <= done;
      if (frame_start) begin
        run_cnt_p0 <= '0;
        if (bit_valid) begin
          shift_p0   <= {2'b00, bit_in};
          bit_cnt_p0 <= 2'd1;
        end else begin
          shift_p0   <= '0;
          bit_cnt_p0 <= '0;
        end
      end else if (accept) begin
        shift_p0   <= {shift_p0[1:0], bit_in};
        bit_cnt_p0 <= bit_cnt_p0 + 2'd1;
        if (done) begin
          nibble_p1  <= nib_word;
          hit_p1     <= lut_hit;
          run_cnt_p0 <= lut_hit ? sat_inc_run(run_cnt_p0) : 4'd0;
        end
      end

      if (cnt_clr)               cnt_p1 <= '0;
      else if (done && lut_hit)  cnt_p1 <= sat_inc_cnt(cnt_p1);

      if (alarm_set)      alarm_p1 <= 1'b1;
      else if (alarm_clr) alarm_p1 <= 1'b0;
    end
  end

  assign nibble       = nibble_p1;
  assign nibble_valid = vld_p1;
  assign kevin_hit    = hit_p1;
  assign hit_count    = cnt_p1;
  assign run_alarm    = alarm_p1;
  assign busy         = (state == COLLECT);

endmodule

// File: tb/tb_kevin_stream_framer.sv
// Self-checking bench: directed vector table plus randomized traffic against a queue-based model.
module tb_kevin_stream_framer;

  localparam int RUN_LEN = 3;

  logic clk = 1'b0;
  logic rst, frame_start, bit_in, bit_valid, cnt_clr, alarm_clr;

  logic [3:0] nibble, nibble2;
  logic       nibble_valid, kevin_hit, run_alarm, busy;
  logic       nibble_valid2, kevin_hit2, run_alarm2, busy2;
  logic [7:0] hit_count;
  logic [1:0] hit_count2;

  always #5 clk = ~clk;

  kevin_stream_framer #(.CNT_W(8), .RUN_LEN(RUN_LEN)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .cnt_clr(cnt_clr), .alarm_clr(alarm_clr),
    .nibble(nibble), .nibble_valid(nibble_valid), .kevin_hit(kevin_hit),
    .hit_count(hit_count), .run_alarm(run_alarm), .busy(busy)
  );

  kevin_stream_framer #(.CNT_W(2), .RUN_LEN(RUN_LEN)) dut2 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .cnt_clr(cnt_clr), .alarm_clr(alarm_clr),
    .nibble(nibble2), .nibble_valid(nibble_valid2), .kevin_hit(kevin_hit2),
    .hit_count(hit_count2), .run_alarm(run_alarm2), .busy(busy2)
  );

  typedef struct {
    logic       rst, fs, bv, b, cc, ac;
    logic       chk;
    logic       nv;
    logic [3:0] nib;
    logic       hit;
    logic [7:0] cnt;
    logic       al;
    logic       busy;
  } vec_t;

  vec_t tab[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;

  // Reference model: pending bits of the current frame kept as a queue
  int m_active, m_nib, m_hit, m_vld, m_cnt, m_cnt2, m_run, m_al;
  int pend[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  task automatic model_step(input vec_t v);
    int val, set_al, inc;
    if (v.rst) begin
      m_active = 0; pend.delete(); m_nib = 0; m_hit = 0; m_vld = 0;
      m_cnt = 0; m_cnt2 = 0; m_run = 0; m_al = 0;
      return;
    end
    m_vld = 0; set_al = 0; inc = 0;
    if (v.fs) begin
      m_active = 1;
      pend.delete();
      m_run = 0;
      if (v.bv) pend.push_back(int'(v.b));
    end else if (m_active != 0 && v.bv) begin
      pend.push_back(int'(v.b));
      if (pend.size() == 4) begin
        val = pend[0] * 8 + pend[1] * 4 + pend[2] * 2 + pend[3];
        pend.delete();
        m_nib = val;
        m_hit = (val inside {1, 5, 6, 7, 9, 10, 12, 14}) ? 1 : 0;
        m_vld = 1;
        if (m_hit != 0) begin
          inc = 1;
          if (m_run + 1 == RUN_LEN) set_al = 1;
          m_run = (m_run < 15) ? m_run + 1 : 15;
        end else begin
          m_run = 0;
        end
      end
    end
    if (v.cc) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (inc != 0) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (set_al != 0) m_al = 1;
    else if (v.ac) m_al = 0;
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; frame_start = v.fs; bit_valid = v.bv; bit_in = v.b;
    cnt_clr = v.cc; alarm_clr = v.ac;
    @(posedge clk);
    model_step(v);
    #1;
    cyc++;
    check("m_nibble_valid", int'(nibble_valid), m_vld);
    check("m_nibble", int'(nibble), m_nib);
    check("m_kevin_hit", int'(kevin_hit), m_hit);
    check("m_hit_count", int'(hit_count), m_cnt);
    check("m_run_alarm", int'(run_alarm), m_al);
    check("m_busy", int'(busy), m_active);
    check("m_hit_count_w2", int'(hit_count2), m_cnt2);
    check("m_nibble_valid_w2", int'(nibble_valid2), m_vld);
    if (v.chk) begin
      check("t_nibble_valid", int'(nibble_valid), int'(v.nv));
      check("t_nibble", int'(nibble), int'(v.nib));
      check("t_kevin_hit", int'(kevin_hit), int'(v.hit));
      check("t_hit_count", int'(hit_count), int'(v.cnt));
      check("t_run_alarm", int'(run_alarm), int'(v.al));
      check("t_busy", int'(busy), int'(v.busy));
    end
  endtask

  task automatic add(input logic r, fs, bv, b, cc, ac, chk, nv,
                     input logic [3:0] nib, input logic hit,
                     input logic [7:0] cnt, input logic al, input logic bz);
    vec_t v;
    v.rst = r; v.fs = fs; v.bv = bv; v.b = b; v.cc = cc; v.ac = ac;
    v.chk = chk; v.nv = nv; v.nib = nib; v.hit = hit; v.cnt = cnt; v.al = al; v.busy = bz;
    tab.push_back(v);
  endtask

  // Four MSB-first bit rows; the last one is checked against the completion
  task automatic nb(input logic [3:0] val, input logic hit, input logic [7:0] cnt,
                    input logic al, input logic cc, input logic ac);
    add(0, 0, 1, val[3], 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, val[2], 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, val[1], 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, val[0], cc, ac, 1, 1, val, hit, cnt, al, 1);
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    cnt_clr = 1'b0; alarm_clr = 1'b0;
    model_step('{rst: 1'b1, default: 1'b0});

    //   rst fs bv b cc ac chk nv nib hit cnt al busy
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    nb(4'd6, 1, 8'd1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 6, 1, 1, 0, 1);
    // frame of 3, 9, 10, 12: first bit rides on frame_start
    add(0, 1, 1, 0, 0, 0, 1, 0, 6, 1, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 1, 1, 3, 0, 1, 0, 1);
    nb(4'd9, 1, 8'd2, 0, 0, 0);
    nb(4'd10, 1, 8'd3, 0, 0, 0);
    nb(4'd12, 1, 8'd4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 12, 1, 4, 0, 1);
    // new run reaching RUN_LEN together with alarm_clr: set wins
    add(0, 1, 0, 0, 0, 0, 1, 0, 12, 1, 4, 0, 1);
    nb(4'd5, 1, 8'd5, 0, 0, 0);
    nb(4'd6, 1, 8'd6, 0, 0, 0);
    nb(4'd7, 1, 8'd7, 1, 0, 1);
    // partial 1,0,1 dropped; frame_start carrying what would be the 4th bit
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 1, 0, 7, 1, 7, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 8, 1, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 8, 0, 1);
    nb(4'd9, 1, 8'd9, 0, 0, 0);
    nb(4'd10, 1, 8'd10, 1, 0, 0);
    // 1,1,1,1 with gaps -> 15, non-hit, run cleared
    add(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 10, 1, 10, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 1, 1, 15, 0, 10, 0, 1);
    nb(4'd12, 1, 8'd11, 0, 0, 0);
    nb(4'd14, 1, 8'd12, 0, 0, 0);
    nb(4'd5, 1, 8'd13, 1, 0, 0);
    // reset mid-frame after 2 bits, then bits without frame_start
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // cnt_clr coinciding with a hit completion
    add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    nb(4'd1, 1, 8'd1, 0, 0, 0);
    nb(4'd6, 1, 8'd0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 6, 1, 0, 0, 1);

    foreach (tab[i]) apply(tab[i]);

    // Randomized traffic, checked against the model only
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      v.rst = ($urandom_range(0, 199) == 0);
      v.fs  = ($urandom_range(0, 19) == 0);
      v.bv  = ($urandom_range(0, 9) < 7);
      v.b   = 1'($urandom_range(0, 1));
      v.cc  = ($urandom_range(0, 49) == 0);
      v.ac  = ($urandom_range(0, 29) == 0);
      v.chk = 1'b0; v.nv = 1'b0; v.nib = '0; v.hit = 1'b0;
      v.cnt = '0; v.al = 1'b0; v.busy = 1'b0;
      apply(v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
